// File: rtl/nvme_burst_pkg.sv
// Shared types and helpers for the NVMe FIFO burst reader.
package nvme_burst_pkg;

   // Reader FSM: waiting for a burst, or moving one out
   typedef enum logic {
      IDLE = 1'b0,
      XFER = 1'b1
   } state_t;

   // Width needed to hold a burst length in the range 0..burst_max
   function automatic int calc_lwidth(input int burst_max);
      return $clog2(burst_max + 1);
   endfunction

endpackage

// File: rtl/nvme_burst_obuf.sv
// Single-entry valid/ready output register with a load port.
// Valid/ready: a beat moves when out_valid & out_ready; while out_valid is
// high and out_ready is low, out_data/out_sop/out_eop hold their values.
module nvme_burst_obuf #(
   parameter int width = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic             load,
   input  logic [width-1:0] load_data,
   input  logic             load_sop,
   input  logic             load_eop,
   input  logic             out_ready,
   output logic             out_valid,
   output logic [width-1:0] out_data,
   output logic             out_sop,
   output logic             out_eop,
   output logic             free
);

   // The entry can take a new beat when empty or when its beat leaves this cycle
   assign free = ~out_valid | out_ready;

   // Output register: flush discards, load replaces, accept empties
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_sop   <= 1'b0;
         out_eop   <= 1'b0;
      end else if (flush) begin
         out_valid <= 1'b0;
      end else if (load) begin
         out_valid <= 1'b1;
         out_data  <= load_data;
         out_sop   <= load_sop;
         out_eop   <= load_eop;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: rtl/nvme_fifo_burst_reader.sv
// NVMe FIFO burst reader: waits for a burst worth of FIFO data, pops it and
// emits it as a sop/eop framed valid/ready stream with a burst length.
// Optional feature macro NVME_BURST_READER_TIMEOUT_EN: releases a partial
// burst after the FIFO has held 1..burst_max-1 entries for timeout idle cycles.
module nvme_fifo_burst_reader
   import nvme_burst_pkg::*;
#(
   parameter int width     = 8,
   parameter int words     = 256,
   parameter int burst_max = 4,
   parameter int timeout   = 64,
   parameter int awidth    = $clog2(words),
   parameter int lwidth    = calc_lwidth(burst_max)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              flush,
   input  logic              fifo_dval,
   input  logic [width-1:0]  fifo_dout,
   input  logic [awidth:0]   fifo_used,
   output logic              fifo_pop,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [width-1:0]  out_data,
   output logic              out_sop,
   output logic              out_eop,
   output logic [lwidth-1:0] out_len,
   output state_t            fsm_state
);

   if (burst_max < 1 || burst_max > words || timeout < 1) begin : g_param_check
      $error("nvme_fifo_burst_reader: illegal parameter set");
   end

   localparam logic [awidth:0] full_avail = (awidth + 1)'(burst_max);

   state_t              state, state_nxt;
   logic [lwidth-1:0]   beat_cnt;
   logic [lwidth-1:0]   len_q, len_nxt;
   logic [awidth:0]     avail;
   logic                obuf_free;
   logic                eop_accept;

   // Head register plus the stored entries; fits awidth+1 bits by construction
   assign avail      = fifo_used + (awidth + 1)'(fifo_dval);
   assign eop_accept = out_valid & out_ready & out_eop;
   assign out_len    = (state == XFER) ? len_q : '0;
   assign fsm_state  = state;

`ifdef NVME_BURST_READER_TIMEOUT_EN
   localparam int tw = (timeout > 1) ? $clog2(timeout) : 1;
   localparam logic [tw-1:0] tmo_last = tw'(timeout - 1);
   logic [tw-1:0] tmo_cnt;
`endif

   // Next state, burst length capture and pop decision; flush overrides all
   always_comb begin
      state_nxt = state;
      len_nxt   = len_q;
      fifo_pop  = 1'b0;
      case (state)
         IDLE: begin
            if (avail >= full_avail) begin
               state_nxt = XFER;
               len_nxt   = lwidth'(burst_max);
            end
`ifdef NVME_BURST_READER_TIMEOUT_EN
            else if ((avail != '0) && (tmo_cnt == tmo_last)) begin
               state_nxt = XFER;
               len_nxt   = lwidth'(avail);
            end
`endif
         end
         XFER: begin
            fifo_pop = fifo_dval & obuf_free & (beat_cnt != len_q);
            if (eop_accept) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
      if (flush) begin
         state_nxt = IDLE;
         fifo_pop  = 1'b0;
      end
   end

   // State, burst length and beat counter registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         len_q    <= '0;
         beat_cnt <= '0;
      end else begin
         state <= state_nxt;
         len_q <= len_nxt;
         if (flush || eop_accept) beat_cnt <= '0;
         else if (fifo_pop)       beat_cnt <= beat_cnt + lwidth'(1);
      end
   end

`ifdef NVME_BURST_READER_TIMEOUT_EN
   // Idle-age of a partial burst; restarts whenever a release is not pending
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tmo_cnt <= '0;
      end else if (flush || state != IDLE || state_nxt != IDLE ||
                   avail == '0 || avail >= full_avail) begin
         tmo_cnt <= '0;
      end else if (tmo_cnt != tmo_last) begin
         tmo_cnt <= tmo_cnt + tw'(1);
      end
   end
`endif

   nvme_burst_obuf #(.width(width)) u_obuf (
      .clk       (clk),
      .reset     (reset),
      .flush     (flush),
      .load      (fifo_pop),
      .load_data (fifo_dout),
      .load_sop  (beat_cnt == '0),
      .load_eop  (beat_cnt == (len_q - lwidth'(1))),
      .out_ready (out_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_sop   (out_sop),
      .out_eop   (out_eop),
      .free      (obuf_free)
   );

endmodule

// File: tb/tb_nvme_fifo_burst_reader.sv
// Self-checking bench for nvme_fifo_burst_reader: a queue-based FIFO model,
// a burst-level reference model checked every cycle, and directed scenarios.
module tb_nvme_fifo_burst_reader;
   import nvme_burst_pkg::*;

   localparam int width     = 8;
   localparam int words     = 256;
   localparam int burst_max = 4;
   localparam int timeout   = 64;
   localparam int awidth    = 8;
   localparam int lwidth    = 3;

   logic              clk = 1'b0;
   logic              reset, flush, fifo_dval, out_ready;
   logic [width-1:0]  fifo_dout;
   logic [awidth:0]   fifo_used;
   logic              fifo_pop, out_valid, out_sop, out_eop;
   logic [width-1:0]  out_data;
   logic [lwidth-1:0] out_len;
   state_t            fsm_state;

   nvme_fifo_burst_reader #(
      .width(width), .words(words), .burst_max(burst_max), .timeout(timeout)
   ) dut (
      .clk(clk), .reset(reset), .flush(flush),
      .fifo_dval(fifo_dval), .fifo_dout(fifo_dout), .fifo_used(fifo_used),
      .fifo_pop(fifo_pop), .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_sop(out_sop), .out_eop(out_eop),
      .out_len(out_len), .fsm_state(fsm_state)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   // ---------------- source FIFO model and expected data ----------------
   logic [width-1:0] fifo_q[$];
   logic [width-1:0] exp_q[$];      // every pushed word, in the order it must leave
   int gap_pct   = 0;
   int ready_pct = 100;

   typedef struct {
      logic [width-1:0]  data;
      logic              sop;
      logic              eop;
      logic [lwidth-1:0] len;
      int                cyc;
   } acc_t;
   acc_t acc_log[$];
   int   cyc = 0;
   logic pop_s;
   logic [lwidth-1:0] len_s;

   task automatic drive_fifo();
      if (fifo_q.size() == 0) begin
         fifo_dval = 1'b0;
         fifo_used = '0;
         fifo_dout = '0;
      end else begin
         // a gap models the read stage lagging: data counted in used, head not yet valid
         fifo_dval = !($urandom_range(99) < gap_pct);
         fifo_used = fifo_dval ? (awidth+1)'(fifo_q.size() - 1) : (awidth+1)'(fifo_q.size());
         fifo_dout = fifo_q[0];
      end
   endtask

   task automatic push_val(input logic [width-1:0] v);
      fifo_q.push_back(v);
      exp_q.push_back(v);
      drive_fifo();
   endtask

   // One clock: observe at negedge, update FIFO and drive inputs 1 after posedge
   task automatic tick();
      @(negedge clk);
      pop_s = fifo_pop;
      len_s = out_len;
      if (out_valid && out_ready)
         acc_log.push_back('{data: out_data, sop: out_sop, eop: out_eop, len: out_len, cyc: cyc});
      @(posedge clk);
      #1;
      cyc++;
      if (flush) begin
         fifo_q.delete();
         flush = 1'b0;
      end else if (pop_s && fifo_q.size() > 0) begin
         void'(fifo_q.pop_front());
      end
      out_ready = ($urandom_range(99) < ready_pct);
      drive_fifo();
   endtask

   // ---------------- reference model + compare process ----------------
   typedef struct {
      logic [width-1:0] data;
      logic             sop;
      logic             eop;
   } beat_t;
   beat_t m_obuf[$];
   bit    m_busy = 0;
   int    m_len  = 0;
   int    m_pops = 0;
   int    m_tmo  = 0;

   always @(negedge clk) begin
      if (reset) begin
         m_obuf.delete();
         exp_q.delete();
         m_busy = 0; m_len = 0; m_pops = 0; m_tmo = 0;
      end else begin
         int  avail;
         bit  exp_pop, accept, ended;
         beat_t b;
         avail   = fifo_q.size();
         exp_pop = m_busy && fifo_dval && (m_pops < m_len) &&
                   (m_obuf.size() == 0 || out_ready) && !flush;
         accept  = (m_obuf.size() != 0) && out_ready;
         ended   = 0;
         check("out_len", 32'(out_len), m_busy ? m_len : 0);
         check("fifo_pop", 32'(fifo_pop), 32'(exp_pop));
         check("out_valid", 32'(out_valid), 32'(m_obuf.size() != 0));
         if (m_obuf.size() != 0) begin
            check("out_data", 32'(out_data), 32'(m_obuf[0].data));
            check("out_sop", 32'(out_sop), 32'(m_obuf[0].sop));
            check("out_eop", 32'(out_eop), 32'(m_obuf[0].eop));
         end
         if (flush) begin
            m_obuf.delete();
            exp_q.delete();
            m_busy = 0; m_pops = 0; m_tmo = 0;
         end else begin
            if (accept) begin
               b = m_obuf.pop_front();
               if (exp_q.size() == 0) check("stream_extra", 32'(b.data), 32'hffff_ffff);
               else check("stream_order", 32'(b.data), 32'(exp_q.pop_front()));
               if (b.eop) begin
                  check("burst_pops", m_pops, m_len);
                  ended = 1;
               end
            end
            if (exp_pop) begin
               m_obuf.push_back('{data: fifo_dout, sop: (m_pops == 0), eop: (m_pops == m_len - 1)});
               m_pops++;
            end
            if (ended) begin
               m_busy = 0;
               m_pops = 0;
            end else if (!m_busy) begin
               if (avail >= burst_max) begin
                  m_busy = 1; m_len = burst_max; m_pops = 0; m_tmo = 0;
               end
`ifdef NVME_BURST_READER_TIMEOUT_EN
               else if (avail != 0 && m_tmo == timeout - 1) begin
                  m_busy = 1; m_len = avail; m_pops = 0; m_tmo = 0;
               end
`endif
               else if (avail > 0 && avail < burst_max) begin
                  if (m_tmo < timeout - 1) m_tmo++;
               end else begin
                  m_tmo = 0;
               end
            end
         end
      end
   end

   // ---------------- directed and random scenarios ----------------
   task automatic check_burst(input string name, input int base, input int len, input logic [width-1:0] first);
      for (int i = 0; i < len; i++) begin
         check({name, "_data"}, 32'(acc_log[base+i].data), 32'(first + width'(i)));
         check({name, "_sop"},  32'(acc_log[base+i].sop),  32'(i == 0));
         check({name, "_eop"},  32'(acc_log[base+i].eop),  32'(i == len - 1));
         check({name, "_len"},  32'(acc_log[base+i].len),  len);
      end
   endtask

   initial begin
      int n, base, seen;
      reset = 1'b1; flush = 1'b0; out_ready = 1'b1;
      fifo_dval = 1'b0; fifo_dout = '0; fifo_used = '0;
      #1;
      check("rst_out_valid", 32'(out_valid), 0);
      check("rst_out_sop",   32'(out_sop), 0);
      check("rst_out_eop",   32'(out_eop), 0);
      check("rst_out_len",   32'(out_len), 0);
      check("rst_out_data",  32'(out_data), 0);
      check("rst_fifo_pop",  32'(fifo_pop), 0);
      check("rst_state",     32'(fsm_state), 32'(IDLE));
      tick(); tick();
      reset = 1'b0;

      // 1: eight entries, ready held high -> two framed bursts of four
      acc_log.delete();
      for (int i = 0; i < 8; i++) push_val(8'h10 + 8'(i));
      for (int i = 0; i < 30; i++) tick();
      check("t1_count", acc_log.size(), 8);
      if (acc_log.size() == 8) begin
         check_burst("t1_b0", 0, 4, 8'h10);
         check_burst("t1_b1", 4, 4, 8'h14);
         check("t1_rate", acc_log[3].cyc - acc_log[0].cyc, 3);
      end

`ifndef NVME_BURST_READER_TIMEOUT_EN
      // 2: residual data never leaves on its own; a fourth word completes the burst
      acc_log.delete();
      seen = 0;
      for (int i = 0; i < 3; i++) push_val(8'h20 + 8'(i));
      for (int i = 0; i < 1000; i++) begin
         tick();
         if (acc_log.size() != 0) seen++;
      end
      check("t2_no_valid", seen, 0);
      push_val(8'h23);
      for (int i = 0; i < 20; i++) tick();
      check("t2_count", acc_log.size(), 4);
      if (acc_log.size() == 4) check_burst("t2", 0, 4, 8'h20);
`else
      // 3: three words released as a length-3 burst after the timeout
      acc_log.delete();
      for (int i = 0; i < 3; i++) push_val(8'h30 + 8'(i));
      n = 0;
      tick();
      while (len_s == 0 && n < 200) begin
         n++;
         tick();
      end
      check("t3_delay", n, 64);
      for (int i = 0; i < 20; i++) tick();
      check("t3_count", acc_log.size(), 3);
      if (acc_log.size() == 3) check_burst("t3", 0, 3, 8'h30);
`endif

      // 4: random ready, dval gaps, pushes and rare flushes
      ready_pct = 50;
      gap_pct   = 25;
      for (int i = 0; i < 2000; i++) begin
         if ($urandom_range(199) == 0) flush = 1'b1;
         else if (fifo_q.size() < 200) begin
            n = $urandom_range(2);
            for (int k = 0; k < n; k++) push_val(8'($urandom));
         end
         tick();
      end
      ready_pct = 100;
      gap_pct   = 0;
      for (int i = 0; i < 30; i++) tick();
      flush = 1'b1;
      tick();
      tick();

      // 5: flush with a beat stalled mid-burst
      acc_log.delete();
      for (int i = 0; i < 4; i++) push_val(8'h50 + 8'(i));
      n = 0;
      while (acc_log.size() < 2 && n < 50) begin
         n++;
         tick();
      end
      check("t5_reached_beat2", acc_log.size(), 2);
      ready_pct = 0;
      out_ready = 1'b0;
      flush = 1'b1;
      tick();
      check("t5_pop_in_flush", 32'(pop_s), 0);
      check("t5_valid_after", 32'(out_valid), 0);
      check("t5_state_after", 32'(fsm_state), 32'(IDLE));
      ready_pct = 100;
      out_ready = 1'b1;
      acc_log.delete();
      for (int i = 0; i < 4; i++) push_val(8'h60 + 8'(i));
      for (int i = 0; i < 20; i++) tick();
      check("t5_count", acc_log.size(), 4);
      if (acc_log.size() == 4) check_burst("t5", 0, 4, 8'h60);

      // 6: asynchronous reset mid-burst, then a clean burst
      acc_log.delete();
      for (int i = 0; i < 4; i++) push_val(8'h70 + 8'(i));
      n = 0;
      while (acc_log.size() < 1 && n < 50) begin
         n++;
         tick();
      end
      ready_pct = 0;
      out_ready = 1'b0;
      #2;
      reset = 1'b1;
      #1;
      check("t6_valid", 32'(out_valid), 0);
      check("t6_sop",   32'(out_sop), 0);
      check("t6_eop",   32'(out_eop), 0);
      check("t6_len",   32'(out_len), 0);
      check("t6_data",  32'(out_data), 0);
      check("t6_pop",   32'(fifo_pop), 0);
      fifo_q.delete();
      drive_fifo();
      tick(); tick();
      reset = 1'b0;
      ready_pct = 100;
      out_ready = 1'b1;
      acc_log.delete();
      for (int i = 0; i < 4; i++) push_val(8'h80 + 8'(i));
      for (int i = 0; i < 20; i++) tick();
      check("t6_count", acc_log.size(), 4);
      if (acc_log.size() == 4) check_burst("t6", 0, 4, 8'h80);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
